// File: rtl/dm_sba_unit.sv
// System bus access engine for the RISC-V debug module: turns sbaddress/sbdata
// CSR accesses into single req/gnt/r_valid bus transactions.
module dm_sba_unit #(
  parameter int BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o
);

  localparam int BeW  = BusWidth / 8;
  localparam int OffW = $clog2(BeW);

  typedef enum logic [2:0] {Idle, Read, Write, WaitRead, WaitWrite} state_e;
  state_e state_q, state_d;

  logic [OffW-1:0]  offset;
  logic             size_err;
  logic [BeW-1:0]   be;
  logic [BusWidth-1:0] addr_inc;

  assign offset   = sbaddress_i[OffW-1:0];
  assign size_err = sbaccess_i > 3'(OffW);
  assign addr_inc = sbaddress_i + (BusWidth'(1) << sbaccess_i);
  assign sbbusy_o = state_q != Idle;

  // Lanes outside the bus word are simply dropped for unaligned accesses.
  always_comb begin
    be = '0;
    for (int b = 0; b < BeW; b++)
      be[b] = (b >= int'(offset)) && (b < int'(offset) + (1 << sbaccess_i));
  end

  always_comb begin
    state_d         = state_q;
    master_req_o    = 1'b0;
    master_we_o     = 1'b0;
    master_add_o    = sbaddress_i;
    master_wdata_o  = '0;
    master_be_o     = '0;
    sbdata_o        = '0;
    sbdata_valid_o  = 1'b0;
    sberror_valid_o = 1'b0;
    sberror_o       = 3'd0;
    sbaddress_o     = sbaddress_i;

    unique case (state_q)
      Idle: begin
        if (sbaddress_write_valid_i && sbreadonaddr_i)   state_d = Read;
        else if (sbdata_write_valid_i)                   state_d = Write;
        else if (sbdata_read_valid_i && sbreadondata_i)  state_d = Read;
      end
      Read, Write: begin
        if (size_err) begin
          sberror_valid_o = 1'b1;
          sberror_o       = 3'd4;
          state_d         = Idle;
        end else begin
          master_req_o = 1'b1;
          master_be_o  = be;
          if (state_q == Write) begin
            master_we_o    = 1'b1;
            master_wdata_o = sbdata_i << {offset, 3'b000};
          end
          if (master_gnt_i) state_d = (state_q == Write) ? WaitWrite : WaitRead;
        end
      end
      WaitRead, WaitWrite: begin
        if (master_r_valid_i) begin
          if (state_q == WaitRead) begin
            sbdata_valid_o = 1'b1;
            sbdata_o       = master_r_rdata_i >> {offset, 3'b000};
          end
          if (sbautoincrement_i) sbaddress_o = addr_inc;
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase

    // An inactive debug module abandons whatever is in flight.
    if (!dmactive_i) begin
      state_d      = Idle;
      master_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= Idle;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_dm_sba_unit.sv
// Randomized scoreboard bench for dm_sba_unit: the driver pushes expected bus
// events from a byte-level model, a negedge monitor pops and compares them.
module tb_dm_sba_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        dmactive_i = 1'b1;
  logic        master_req_o, master_we_o;
  logic [31:0] master_add_o, master_wdata_o;
  logic [3:0]  master_be_o;
  logic        master_gnt_i = 1'b0, master_r_valid_i = 1'b0;
  logic [31:0] master_r_rdata_i = '0;
  logic [31:0] sbaddress_i = '0, sbaddress_o;
  logic        sbaddress_write_valid_i = 1'b0, sbreadonaddr_i = 1'b0;
  logic        sbautoincrement_i = 1'b0, sbreadondata_i = 1'b0;
  logic [2:0]  sbaccess_i = 3'd2;
  logic [31:0] sbdata_i = '0, sbdata_o;
  logic        sbdata_read_valid_i = 1'b0, sbdata_write_valid_i = 1'b0;
  logic        sbdata_valid_o, sbbusy_o, sberror_valid_o;
  logic [2:0]  sberror_o;

  dm_sba_unit #(.BusWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dmactive_i(dmactive_i),
    .master_req_o(master_req_o), .master_add_o(master_add_o), .master_we_o(master_we_o),
    .master_wdata_o(master_wdata_o), .master_be_o(master_be_o), .master_gnt_i(master_gnt_i),
    .master_r_valid_i(master_r_valid_i), .master_r_rdata_i(master_r_rdata_i),
    .sbaddress_i(sbaddress_i), .sbaddress_o(sbaddress_o),
    .sbaddress_write_valid_i(sbaddress_write_valid_i), .sbreadonaddr_i(sbreadonaddr_i),
    .sbautoincrement_i(sbautoincrement_i), .sbaccess_i(sbaccess_i),
    .sbreadondata_i(sbreadondata_i), .sbdata_i(sbdata_i),
    .sbdata_read_valid_i(sbdata_read_valid_i), .sbdata_write_valid_i(sbdata_write_valid_i),
    .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o), .sbbusy_o(sbbusy_o),
    .sberror_valid_o(sberror_valid_o), .sberror_o(sberror_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int EV_REQ = 0, EV_DONE = 1, EV_ERR = 2;
  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] add, wdata, rdata, next_addr;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ev(int k);
    exp_t e;
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", k, $time);
      return;
    end
    e = q.pop_front();
    chk("ev_kind", k, e.kind);
    case (k)
      EV_REQ: begin
        chk("req_add", master_add_o, e.add);
        chk("req_we", {31'd0, master_we_o}, {31'd0, e.we});
        if (e.we) begin
          chk("req_be", {28'd0, master_be_o}, {28'd0, e.be});
          chk("req_wdata", master_wdata_o, e.wdata);
        end
      end
      EV_DONE: begin
        chk("done_addr", sbaddress_o, e.next_addr);
        chk("done_dvalid", {31'd0, sbdata_valid_o}, {31'd0, !e.we});
        if (!e.we) chk("done_rdata", sbdata_o, e.rdata);
      end
      default: begin
        chk("err_code", {29'd0, sberror_o}, 32'd4);
        chk("err_noreq", {31'd0, master_req_o}, 32'd0);
      end
    endcase
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (master_req_o && master_gnt_i)   ev(EV_REQ);
      if (sberror_valid_o)                ev(EV_ERR);
      if (master_r_valid_i && sbbusy_o)   ev(EV_DONE);
      if (sbdata_valid_o && !master_r_valid_i) begin
        checks++; failures++;
        $display("FAIL spurious_dvalid: got 1 expected 0 at %0t", $time);
      end
    end
  end

  // kind: 0 write, 1 read-on-address, 2 read-on-data. Called at posedge+1.
  task automatic txn(int kind, logic [31:0] addr, logic [31:0] data, logic [2:0] acc,
                     bit ainc, int gd, int rd, logic [31:0] rdat, bit both, bit noise);
    exp_t r, d;
    int nb, off;
    bit err;
    err = acc > 3'd2;
    nb  = 1 << acc;
    off = addr % 4;
    sbaddress_i = addr; sbdata_i = data; sbaccess_i = acc; sbautoincrement_i = ainc;
    case (kind)
      0: sbdata_write_valid_i = 1'b1;
      1: begin sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1; sbdata_write_valid_i = both; end
      default: begin sbdata_read_valid_i = 1'b1; sbreadondata_i = 1'b1; end
    endcase
    if (err) begin
      r.kind = EV_ERR; q.push_back(r);
    end else begin
      r.kind = EV_REQ; r.add = addr; r.we = (kind == 0);
      r.be = '0;
      for (int b = 0; b < 4; b++) r.be[b] = (b >= off) && (b < off + nb);
      r.wdata = data << (8 * off);
      d = r; d.kind = EV_DONE;
      d.rdata = rdat >> (8 * off);
      d.next_addr = ainc ? addr + nb : addr;
      q.push_back(r); q.push_back(d);
    end
    @(posedge clk_i); #1;
    sbdata_write_valid_i = 0; sbaddress_write_valid_i = 0; sbdata_read_valid_i = 0;
    sbreadonaddr_i = 0; sbreadondata_i = 0;
    if (err) begin
      @(posedge clk_i); #1;
      chk("err_idle", {31'd0, sbbusy_o}, 32'd0);
      chk("sb_drain", q.size(), 0);
      return;
    end
    for (int i = 0; i < gd; i++) begin
      @(negedge clk_i);
      chk("req_hold", {31'd0, master_req_o}, 32'd1);
      chk("req_hold_add", master_add_o, addr);
      @(posedge clk_i); #1;
    end
    master_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    master_gnt_i = 1'b0;
    for (int i = 0; i < rd; i++) begin
      if (noise && i == 0) sbdata_write_valid_i = 1'b1;
      @(posedge clk_i); #1;
      sbdata_write_valid_i = 1'b0;
    end
    master_r_valid_i = 1'b1; master_r_rdata_i = rdat;
    @(posedge clk_i); #1;
    master_r_valid_i = 1'b0;
    chk("idle_after", {31'd0, sbbusy_o}, 32'd0);
    chk("sb_drain", q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t r;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", {31'd0, master_req_o}, 32'd0);
    chk("rst_busy", {31'd0, sbbusy_o}, 32'd0);
    chk("rst_dvalid", {31'd0, sbdata_valid_o}, 32'd0);
    chk("rst_errvalid", {31'd0, sberror_valid_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed cases from the block's intended use
    txn(0, 32'h1000, 32'hDEADBEEF, 3'd2, 0, 0, 0, 32'h0, 0, 0);
    txn(1, 32'h2004, 32'h0, 3'd2, 0, 1, 1, 32'h12345678, 0, 0);
    txn(0, 32'h1003, 32'hAB, 3'd0, 0, 0, 0, 32'h0, 0, 0);
    txn(2, 32'hFFFFFFFC, 32'h0, 3'd2, 1, 0, 0, 32'hCAFEF00D, 0, 0);
    txn(0, 32'h1000, 32'h55, 3'd3, 0, 0, 0, 32'h0, 0, 0);
    txn(1, 32'h3000, 32'h77, 3'd1, 0, 0, 2, 32'hA5A5_1234, 1, 1);

    // Non-triggering CSR accesses leave the engine idle
    sbaddress_write_valid_i = 1; sbdata_read_valid_i = 1;
    @(posedge clk_i); #1;
    sbaddress_write_valid_i = 0; sbdata_read_valid_i = 0;
    chk("no_trigger", {31'd0, sbbusy_o}, 32'd0);

    // dmactive dropped in WaitRead after a slow grant
    sbaddress_i = 32'h4000; sbaccess_i = 3'd2; sbautoincrement_i = 1'b0;
    sbaddress_write_valid_i = 1; sbreadonaddr_i = 1;
    r.kind = EV_REQ; r.add = 32'h4000; r.we = 1'b0; r.be = 4'hF; r.wdata = '0;
    q.push_back(r);
    @(posedge clk_i); #1;
    sbaddress_write_valid_i = 0; sbreadonaddr_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("dm_req_hold", {31'd0, master_req_o}, 32'd1);
      @(posedge clk_i); #1;
    end
    master_gnt_i = 1; @(posedge clk_i); #1; master_gnt_i = 0;
    chk("dm_waitread_busy", {31'd0, sbbusy_o}, 32'd1);
    dmactive_i = 0; @(posedge clk_i); #1; dmactive_i = 1;
    chk("dm_drop_idle", {31'd0, sbbusy_o}, 32'd0);
    chk("dm_drain", q.size(), 0);

    // Asynchronous reset during a pending write request
    sbdata_write_valid_i = 1;
    @(posedge clk_i); #1;
    sbdata_write_valid_i = 0;
    chk("pre_rst_req", {31'd0, master_req_o}, 32'd1);
    rst_i = 1; #1;
    chk("async_rst_busy", {31'd0, sbbusy_o}, 32'd0);
    chk("async_rst_req", {31'd0, master_req_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(posedge clk_i); #1;

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [2:0]  acc;
      a   = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : $urandom;
      acc = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      txn($urandom_range(0, 2), a, $urandom, acc, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk_i);
    chk("final_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_sba_unit.md
# dm_sba_unit

System Bus Access (SBA) engine of the RISC-V debug module. It turns sbaddress/sbdata accesses requested by the debug CSR block into single req/gnt/r_valid transactions on the system-bus master port. It also returns read data, auto-increments the address and reports busy and error status back to the CSRs. It sits between the DM CSR file and the SoC interconnect.

## Interface

- BusWidth, default 32: data and address width; only 32 or 64 are legal.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- dmactive_i  in  1  debug module active; low forces Idle.
- master_req_o  out  1  bus request.
- master_add_o  out  BusWidth  bus address.
- master_we_o  out  1  write enable.
- master_wdata_o  out  BusWidth  write data.
- master_be_o  out  BusWidth/8  byte enables.
- master_gnt_i  in  1  request accepted.
- master_r_valid_i  in  1  response valid; read data or write acknowledge.
- master_r_rdata_i  in  BusWidth  read data.
- sbaddress_i  in  BusWidth  current sbaddress from the CSRs.
- sbaddress_o  out  BusWidth  next sbaddress after auto-increment.
- sbaddress_write_valid_i  in  1  CSRs wrote sbaddress this cycle.
- sbreadonaddr_i  in  1  start a read on an sbaddress write.
- sbautoincrement_i  in  1  increment the address after each access.
- sbaccess_i  in  3  access size as log2 of bytes (0=8b, 1=16b, 2=32b, 3=64b).
- sbreadondata_i  in  1  start a read on an sbdata read.
- sbdata_i  in  BusWidth  data to write.
- sbdata_read_valid_i  in  1  CSRs read sbdata this cycle.
- sbdata_write_valid_i  in  1  CSRs wrote sbdata this cycle.
- sbdata_o  out  BusWidth  read result.
- sbdata_valid_o  out  1  one-cycle strobe marking sbdata_o valid.
- sbbusy_o  out  1  engine not idle.
- sberror_valid_o  out  1  one-cycle strobe marking sberror_o valid.
- sberror_o  out  3  error code; 4 means unsupported size.

## Operation

- FSM states: Idle, Read, Write, WaitRead, WaitWrite. Only the state is registered; every output is combinational from the state and the inputs.
- Transitions out of Idle, highest priority first:
  - sbaddress_write_valid_i && sbreadonaddr_i -> Read.
  - sbdata_write_valid_i -> Write.
  - sbdata_read_valid_i && sbreadondata_i -> Read.
- Read state:
  - Drives master_req_o=1, master_we_o=0, master_add_o=sbaddress_i.
  - On master_gnt_i -> WaitRead.
- Write state:
  - Drives master_req_o=1, master_we_o=1, master_add_o=sbaddress_i.
  - master_wdata_o = sbdata_i << (8*offset), where offset = sbaddress_i[log2(BusWidth/8)-1:0].
  - On master_gnt_i -> WaitWrite.
- Byte enables: master_be_o = ((1<<(1<<sbaccess_i))-1) << offset, truncated to BusWidth/8 bits.
- WaitRead: on master_r_valid_i, pulse sbdata_valid_o=1 with sbdata_o = master_r_rdata_i >> (8*offset), then -> Idle.
- WaitWrite: on master_r_valid_i -> Idle.
- Auto-increment: sbaddress_o = sbaddress_i at all times, except in the completion cycle (r_valid in WaitRead or WaitWrite) with sbautoincrement_i=1. In that cycle sbaddress_o = sbaddress_i + (1<<sbaccess_i), modulo 2^BusWidth, wrapping silently.
- Size error: in Read or Write with sbaccess_i > log2(BusWidth/8):
  - no request is issued (master_req_o=0);
  - sberror_valid_o=1 and sberror_o=4 pulse for one cycle;
  - state -> Idle.
- sbbusy_o = (state != Idle).
- Requests arriving while busy are ignored; the CSR block is responsible for flagging sbbusyerror.
- dmactive_i=0 forces the next state to Idle from any state, and master_req_o is 0 that cycle.
- Default output values when not driven: req, we, sbdata_valid_o and sberror_valid_o are 0; master_add_o = sbaddress_i; master_wdata_o, master_be_o, sbdata_o and sberror_o are 0.

## Timing

- Reset: state=Idle. All strobes, master_req_o and sbbusy_o are 0.
- A trigger in cycle N raises master_req_o in cycle N+1.
- master_req_o and the address, data and be remain stable until the cycle in which master_gnt_i=1. gnt may arrive in the first request cycle.
- r_valid is sampled only in the Wait states, so the earliest r_valid is the cycle after gnt.
- sbdata_valid_o and the incremented sbaddress_o appear in the same cycle as r_valid. The engine is Idle the cycle after.
- Minimum access is 3 cycles: trigger, req+gnt, r_valid. The next trigger may arrive in the cycle after completion.
- An error pulse appears in the cycle after the trigger; Idle follows.
- An asynchronous reset mid-transaction returns the FSM to Idle immediately. The in-flight response is dropped.

## Test plan

- BusWidth=32, sbaddress=0x1000, sbaccess=2, sbdata write 0xDEADBEEF -> next cycle req=1, we=1, add=0x1000, be=0xF, wdata=0xDEADBEEF; gnt then r_valid -> Idle, sbbusy_o drops.
- sbreadonaddr=1 with sbaddress write 0x2004, rdata=0x12345678 -> req, we=0, add=0x2004; sbdata_valid_o=1 and sbdata_o=0x12345678 with r_valid.
- Byte write at 0x1003, sbaccess=0, sbdata=0xAB -> be=0x8, wdata=0xAB000000.
- sbautoincrement=1, sbaccess=2, sbaddress=0xFFFFFFFC, read -> sbaddress_o=0x00000000 with r_valid.
- BusWidth=32, sbaccess=3 write -> no req, sberror_valid_o=1 with sberror_o=4 for one cycle, then Idle.
- gnt delayed 3 cycles, then dmactive_i dropped during WaitRead -> req held stable until gnt; Idle next cycle after dmactive_i drops, sbbusy_o=0.
